// File: rtl/ps2_pkg.sv
// Shared PS/2 host definitions: command/response bytes and the mouse_init sequencer states.
package ps2_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_ERROR    = 8'hFC;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_ID       = 8'h00;

  typedef enum logic [3:0] {
    S_SEND_RESET,
    S_WAIT_RESET_ACK,
    S_WAIT_BAT,
    S_WAIT_ID,
    S_SEND_RATE_CMD,
    S_WAIT_RATE_CMD_ACK,
    S_SEND_RATE_VAL,
    S_WAIT_RATE_VAL_ACK,
    S_SEND_ENABLE,
    S_WAIT_ENABLE_ACK,
    S_DONE,
    S_FAIL
  } state_t;

  function automatic logic is_send(state_t s);
    return (s == S_SEND_RESET) || (s == S_SEND_RATE_CMD) ||
           (s == S_SEND_RATE_VAL) || (s == S_SEND_ENABLE);
  endfunction

  function automatic logic is_wait(state_t s);
    return (s == S_WAIT_RESET_ACK) || (s == S_WAIT_BAT) || (s == S_WAIT_ID) ||
           (s == S_WAIT_RATE_CMD_ACK) || (s == S_WAIT_RATE_VAL_ACK) ||
           (s == S_WAIT_ENABLE_ACK);
  endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// Per-state response timer: expired pulses on the TIMEOUT_CYCLES-th enabled cycle since clear.
// clear is seen during the first cycle of a state, so that cycle already counts as elapsed 0.
module ps2_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES);

  logic [W-1:0] cnt;
  logic [W-1:0] elapsed;

  assign elapsed = clear ? '0 : cnt;
  assign expired = enable && (elapsed == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= elapsed + W'(1);
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/mouse_init.sv
// PS/2 mouse bring-up sequencer: reset, self-test check, sample rate, enable reporting.
// Drives the shared PS2_Controller transmit path and validates every response byte.
module mouse_init
  import ps2_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 50_000_000,
  parameter int         MAX_RETRIES    = 3,
  parameter logic [7:0] SAMPLE_RATE    = 8'd100
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  output logic [7:0] the_command,
  output logic       send_command,
  output logic       stream_en,
  output logic       init_fail,
  output logic [1:0] retry_count
);

  state_t     state;
  state_t     state_nxt;
  state_t     advance;
  state_t     resend;
  logic [7:0] expect_byte;
  logic       take;
  logic       restart;
  logic       tmr_clear;
  logic       tmr_enable;
  logic       tmr_expired;

  assign tmr_enable = is_send(state) || is_wait(state);

  ps2_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (CLOCK_50),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

  function automatic logic [7:0] cmd_of(state_t s);
    case (s)
      S_SEND_RATE_CMD: return CMD_SET_RATE;
      S_SEND_RATE_VAL: return SAMPLE_RATE;
      S_SEND_ENABLE:   return CMD_ENABLE;
      default:         return CMD_RESET;
    endcase
  endfunction

  // Step table: where each state goes on success, what it expects, and where a resend returns.
  always_comb begin
    expect_byte = RSP_ACK;
    advance     = state;
    resend      = S_SEND_RESET;
    case (state)
      S_SEND_RESET:        advance = S_WAIT_RESET_ACK;
      S_WAIT_RESET_ACK:    advance = S_WAIT_BAT;
      S_WAIT_BAT:          begin expect_byte = RSP_BAT_OK; advance = S_WAIT_ID; end
      S_WAIT_ID:           begin expect_byte = RSP_ID; advance = S_SEND_RATE_CMD; end
      S_SEND_RATE_CMD:     advance = S_WAIT_RATE_CMD_ACK;
      S_WAIT_RATE_CMD_ACK: begin advance = S_SEND_RATE_VAL; resend = S_SEND_RATE_CMD; end
      S_SEND_RATE_VAL:     advance = S_WAIT_RATE_VAL_ACK;
      S_WAIT_RATE_VAL_ACK: begin advance = S_SEND_ENABLE; resend = S_SEND_RATE_VAL; end
      S_SEND_ENABLE:       advance = S_WAIT_ENABLE_ACK;
      S_WAIT_ENABLE_ACK:   begin advance = S_DONE; resend = S_SEND_ENABLE; end
      default:             ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    restart   = 1'b0;
    if (is_send(state)) begin
      if (error_communication_timed_out || (!command_was_sent && tmr_expired)) begin
        restart = 1'b1;
      end else if (command_was_sent) begin
        take      = 1'b1;
        state_nxt = advance;
      end
    end else if (is_wait(state)) begin
      if (received_data_en) begin
        if (received_data == expect_byte) begin
          take      = 1'b1;
          state_nxt = advance;
        end else if (received_data == RSP_RESEND) begin
          take      = 1'b1;
          state_nxt = resend;
        end else begin
          restart = 1'b1;
        end
      end else if (tmr_expired) begin
        restart = 1'b1;
      end
    end
    if (restart) begin
      take      = 1'b1;
      state_nxt = (int'(retry_count) < MAX_RETRIES) ? S_SEND_RESET : S_FAIL;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= S_SEND_RESET;
      the_command  <= 8'h00;
      send_command <= 1'b0;
      stream_en    <= 1'b0;
      init_fail    <= 1'b0;
      retry_count  <= 2'd0;
      tmr_clear    <= 1'b1;
    end else begin
      state        <= state_nxt;
      tmr_clear    <= take;
      send_command <= is_send(state_nxt);
      stream_en    <= (state_nxt == S_DONE);
      if (is_send(state_nxt)) begin
        the_command <= cmd_of(state_nxt);
      end
      if (restart && (state_nxt == S_SEND_RESET)) begin
        retry_count <= retry_count + 2'd1;
      end
      if (state_nxt == S_FAIL) begin
        init_fail <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mouse_init.sv
// Bench for mouse_init: PS2_Controller/mouse behavioural model, directed table and random scripts.
module tb_mouse_init;

  localparam int         TMO   = 64;
  localparam int         MAXR  = 3;
  localparam int         NSTEP = 10;
  localparam logic [8:0] M     = 9'h100;  // end of the reply group for one transmitted command

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       command_was_sent = 1'b0;
  logic       error_communication_timed_out = 1'b0;
  logic [7:0] the_command;
  logic       send_command;
  logic       stream_en;
  logic       init_fail;
  logic [1:0] retry_count;

  always #5 clk = ~clk;

  mouse_init #(
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRIES   (MAXR),
    .SAMPLE_RATE   (8'd100)
  ) dut (
    .CLOCK_50                     (clk),
    .reset                        (reset),
    .received_data                (received_data),
    .received_data_en             (received_data_en),
    .command_was_sent             (command_was_sent),
    .error_communication_timed_out(error_communication_timed_out),
    .the_command                  (the_command),
    .send_command                 (send_command),
    .stream_en                    (stream_en),
    .init_fail                    (init_fail),
    .retry_count                  (retry_count)
  );

  bit         step_send [NSTEP] = '{1, 0, 0, 0, 1, 0, 1, 0, 1, 0};
  logic [7:0] step_byte [NSTEP] = '{8'hFF, 8'hFA, 8'hAA, 8'h00, 8'hF3,
                                    8'hFA, 8'h64, 8'hFA, 8'hF4, 8'hFA};

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0, busy = 0, ack_cnt = 0, gap_cnt = 0, send_idx = 0, n_rx = 0;
  int ack_delay = 10, rsp_gap = 5;
  int last_ack_cyc = 0, last_rx_cyc = 0, stream_cyc = -1, fail_cyc = -1;
  logic [8:0] b9;
  logic [8:0] script_q[$];
  bit         err_at[$];
  logic [7:0] rq[$];
  logic [7:0] sent_q[$];
  int         gap_q[$];

  logic [8:0] gscript[$];
  bit         gerr[$];
  logic [7:0] exp_cmds[$];
  int         exp_retry;
  logic       exp_done, exp_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // PS2_Controller + mouse: ack each request after ack_delay, then play the next reply group.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      command_was_sent = 1'b0;
      error_communication_timed_out = 1'b0;
      received_data_en = 1'b0;
      if (reset) begin
        busy = 0; send_idx = 0; rq.delete(); stream_cyc = -1; fail_cyc = -1;
      end else begin
        if (busy != 0) begin
          ack_cnt--;
          if (ack_cnt == 0) begin
            busy = 0;
            command_was_sent = 1'b1;
            last_ack_cyc = cyc;
            gap_cnt = rsp_gap;
            if (send_idx < err_at.size() && err_at[send_idx]) begin
              error_communication_timed_out = 1'b1;
            end else begin
              while (script_q.size() > 0) begin
                b9 = script_q.pop_front();
                if (b9 == M) break;
                rq.push_back(b9[7:0]);
              end
            end
            send_idx++;
          end
        end else if (send_command) begin
          busy = 1;
          ack_cnt = ack_delay;
          sent_q.push_back(the_command);
          if (sent_q.size() > 1) gap_q.push_back(cyc - last_ack_cyc);
        end else if (rq.size() > 0) begin
          gap_cnt--;
          if (gap_cnt == 0) begin
            received_data = rq.pop_front();
            received_data_en = 1'b1;
            last_rx_cyc = cyc;
            n_rx++;
            gap_cnt = rsp_gap;
          end
        end
        if (stream_en && stream_cyc < 0) stream_cyc = cyc;
        if (init_fail && fail_cyc < 0) fail_cyc = cyc;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, " the_command"}, 32'(the_command), 32'h00);
    check({tag, " send_command"}, 32'(send_command), 32'h0);
    check({tag, " stream_en"}, 32'(stream_en), 32'h0);
    check({tag, " init_fail"}, 32'(init_fail), 32'h0);
    check({tag, " retry_count"}, 32'(retry_count), 32'h0);
  endtask

  task automatic start_run(input string tag, input logic [8:0] scr[$], input bit errs[$]);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    script_q = scr;
    err_at = errs;
    sent_q.delete();
    gap_q.delete();
    n_rx = 0;
    check_reset_vals(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int k = 0;
    while (!stream_en && !init_fail && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check({tag, " finished"}, 32'(stream_en | init_fail), 32'h1);
    repeat (30) @(negedge clk);
  endtask

  task automatic check_result(input string tag, input logic [7:0] ecmds[$], input int eretry,
                              input logic edone, input logic efail);
    check({tag, " n_cmds"}, 32'(sent_q.size()), 32'(ecmds.size()));
    for (int k = 0; k < ecmds.size() && k < sent_q.size(); k++)
      check($sformatf("%s cmd%0d", tag, k), 32'(sent_q[k]), 32'(ecmds[k]));
    check({tag, " retry_count"}, 32'(retry_count), 32'(eretry));
    check({tag, " stream_en"}, 32'(stream_en), 32'(edone));
    check({tag, " init_fail"}, 32'(init_fail), 32'(efail));
    check({tag, " send_idle"}, 32'(send_command), 32'h0);
    if (edone) check({tag, " stream_lat"}, 32'(stream_cyc - last_rx_cyc), 32'd1);
  endtask

  function automatic int prev_send(input int step);
    int s = step;
    while (s > 0 && !step_send[s]) s--;
    return s;
  endfunction

  // Walks the step list directly, choosing replies at random and recording what must follow.
  task automatic gen_random();
    int step = 0, guard = 0;
    bit rst;
    logic [7:0] b;
    gscript.delete(); gerr.delete(); exp_cmds.delete();
    exp_retry = 0; exp_done = 1'b0; exp_fail = 1'b0;
    while (!exp_done && !exp_fail) begin
      guard++;
      rst = 1'b0;
      if (step == NSTEP) begin
        exp_done = 1'b1;
      end else if (step_send[step]) begin
        exp_cmds.push_back(step_byte[step]);
        if (guard < 60 && $urandom_range(14) == 0) begin
          gerr.push_back(1'b1);
          rst = 1'b1;
        end else begin
          gerr.push_back(1'b0);
          step++;
        end
      end else begin
        case ((guard < 60) ? $urandom_range(9) : 0)
          8: b = 8'hFE;
          9: do b = 8'($urandom); while (b == step_byte[step] || b == 8'hFE);
          default: b = step_byte[step];
        endcase
        gscript.push_back({1'b0, b});
        if (b == step_byte[step]) begin
          step++;
          if (step == NSTEP || step_send[step]) gscript.push_back(M);
        end else if (b == 8'hFE) begin
          gscript.push_back(M);
          step = prev_send(step);
        end else begin
          gscript.push_back(M);
          rst = 1'b1;
        end
      end
      if (rst) begin
        if (exp_retry < MAXR) begin
          exp_retry++;
          step = 0;
        end else begin
          exp_fail = 1'b1;
        end
      end
    end
  endtask

  typedef struct {
    string      name;
    logic [8:0] scr[$];
    int         err_send;
    logic [7:0] cmds[$];
    int         retry;
    logic       done;
    logic       fail;
  } vec_t;

  initial begin
    vec_t v[5];
    bit   errs[$];
    bit   no_err[$];
    int   k;

    v[0].name = "nominal";  v[0].err_send = -1; v[0].retry = 0; v[0].done = 1; v[0].fail = 0;
    v[0].scr  = '{9'h0FA, 9'h0AA, 9'h000, M, 9'h0FA, M, 9'h0FA, M, 9'h0FA, M};
    v[0].cmds = '{8'hFF, 8'hF3, 8'h64, 8'hF4};
    v[1].name = "resend";   v[1].err_send = -1; v[1].retry = 0; v[1].done = 1; v[1].fail = 0;
    v[1].scr  = '{9'h0FA, 9'h0AA, 9'h000, M, 9'h0FE, M, 9'h0FA, M, 9'h0FA, M, 9'h0FA, M};
    v[1].cmds = '{8'hFF, 8'hF3, 8'hF3, 8'h64, 8'hF4};
    v[2].name = "bad_bat";  v[2].err_send = -1; v[2].retry = 1; v[2].done = 1; v[2].fail = 0;
    v[2].scr  = '{9'h0FA, 9'h0FC, M, 9'h0FA, 9'h0AA, 9'h000, M, 9'h0FA, M, 9'h0FA, M, 9'h0FA, M};
    v[2].cmds = '{8'hFF, 8'hFF, 8'hF3, 8'h64, 8'hF4};
    v[3].name = "silent";   v[3].err_send = -1; v[3].retry = 3; v[3].done = 0; v[3].fail = 1;
    v[3].cmds = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    v[4].name = "tx_error"; v[4].err_send = 3;  v[4].retry = 1; v[4].done = 1; v[4].fail = 0;
    v[4].scr  = '{9'h0FA, 9'h0AA, 9'h000, M, 9'h0FA, M, 9'h0FA, M,
                  9'h0FA, 9'h0AA, 9'h000, M, 9'h0FA, M, 9'h0FA, M, 9'h0FA, M};
    v[4].cmds = '{8'hFF, 8'hF3, 8'h64, 8'hF4, 8'hFF, 8'hF3, 8'h64, 8'hF4};

    ack_delay = 10;
    rsp_gap = 5;
    for (int i = 0; i < 5; i++) begin
      errs.delete();
      for (int e = 0; e < v[i].err_send; e++) errs.push_back(1'b0);
      if (v[i].err_send >= 0) errs.push_back(1'b1);
      start_run({v[i].name, " reset"}, v[i].scr, errs);
      wait_end(v[i].name);
      check_result(v[i].name, v[i].cmds, v[i].retry, v[i].done, v[i].fail);
      if (v[i].fail) begin
        // Each wait state lasts TMO cycles and is first visible one negedge after the ack.
        check({v[i].name, " n_gaps"}, 32'(gap_q.size()), 32'd3);
        foreach (gap_q[g]) check($sformatf("%s gap%0d", v[i].name, g), 32'(gap_q[g]), 32'(TMO + 1));
        check({v[i].name, " fail_lat"}, 32'(fail_cyc - last_ack_cyc), 32'(TMO + 1));
      end
    end

    start_run("rst_first", '{9'h0FA, M}, no_err);
    k = 0;
    while (!send_command && k < 100) begin @(negedge clk); k++; end
    check("rst_send_seen", 32'(send_command), 32'h1);
    start_run("rst_mid_send", '{9'h0FA, M}, no_err);
    k = 0;
    while (n_rx == 0 && k < 200) begin @(negedge clk); k++; end
    check("rst_ack_seen", 32'(n_rx), 32'd1);
    start_run("rst_wait_bat", v[0].scr, no_err);
    wait_end("rst_rerun");
    check_result("rst_rerun", v[0].cmds, 0, 1'b1, 1'b0);

    for (int r = 0; r < 20; r++) begin
      ack_delay = $urandom_range(20, 2);
      rsp_gap = $urandom_range(20, 1);
      gen_random();
      start_run($sformatf("rnd%0d reset", r), gscript, gerr);
      wait_end($sformatf("rnd%0d", r));
      check_result($sformatf("rnd%0d", r), exp_cmds, exp_retry, exp_done, exp_fail);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mouse_init.md
# mouse_init

Host-side PS/2 mouse command sequencer: after reset it drives the PS2_Controller transmit path to reset and configure the mouse, and checks every response byte. It sits beside the `mouse` packet decoder and shares the same PS2_Controller instance. It asserts `stream_en` only once the mouse acknowledges Enable Data Reporting; the decoder must ignore `received_data_en` until then. Retries, timeouts and failure are reported to the top level.

## Interface
- `TIMEOUT_CYCLES`, default 50_000_000: wait limit per response (1 s at 50 MHz); minimum 16.
- `MAX_RETRIES`, default 3: full-sequence restarts allowed before failure.
- `SAMPLE_RATE`, default 8'd100: argument sent after the 0xF3 command.

Ports:
- `CLOCK_50` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `received_data` in 8: byte from PS2_Controller.
- `received_data_en` in 1: one-cycle strobe, `received_data` valid.
- `command_was_sent` in 1: PS2_Controller transmit complete.
- `error_communication_timed_out` in 1: PS2_Controller transmit failure.
- `the_command` out 8: byte to transmit.
- `send_command` out 1: transmit request (level).
- `stream_en` out 1: initialisation succeeded; decoder may consume bytes.
- `init_fail` out 1: retries exhausted; sticky until reset.
- `retry_count` out 2: restarts so far.

## Operation
- Reset values: `the_command`=0x00, `send_command`=0, `stream_en`=0, `init_fail`=0, `retry_count`=0, FSM=S_SEND_RESET.
- Step list, each a send or an expect:
  1. send 0xFF, expect 0xFA.
  2. expect 0xAA.
  3. expect 0x00.
  4. send 0xF3, expect 0xFA.
  5. send `SAMPLE_RATE`, expect 0xFA.
  6. send 0xF4, expect 0xFA.
  7. S_DONE.
- Send states (S_SEND_*): load `the_command` and hold `send_command`=1 until `command_was_sent` or `error_communication_timed_out`. Deassert on the following edge, then go to the matching S_WAIT_*.
- Wait states: on `received_data_en`:
  - expected byte: advance.
  - 0xFE (resend): re-enter the preceding send state; does not count as a retry.
  - any other byte, including 0xFC: restart.
- Restart:
  - If `retry_count` < `MAX_RETRIES`: increment `retry_count`, go to S_SEND_RESET.
  - Otherwise: go to S_FAIL and set `init_fail`=1.
- Restart triggers:
  - a wrong byte in a wait state;
  - `error_communication_timed_out` in a send state;
  - the timeout counter reaching `TIMEOUT_CYCLES`-1 in any send or wait state.
- S_DONE: `stream_en`=1, all inputs ignored, no further transmission.
- S_FAIL: `send_command`=0, all inputs ignored.
- Simultaneous events:
  - `command_was_sent` together with `error_communication_timed_out`: the error wins.
  - `received_data_en` on the timeout's terminal cycle: the byte wins.
- `reset` mid-transfer returns to the reset state on the next edge. `send_command` drops the same edge.

## Timing
- Timeout counter zeroes on every state entry and counts every cycle while in a send or wait state.
- Latency:
  - S_SEND_* entry to `send_command`=1: 0 cycles, registered with the state.
  - `command_was_sent` to S_WAIT_*: 1 cycle.
  - Matched `received_data_en` to next state: 1 cycle.
- `stream_en` rises exactly 1 cycle after the strobe carrying the final 0xFA.
- Bytes arriving in send states are discarded.

## Structure
- Shared package `ps2_pkg`:
  - command constants: CMD_RESET 0xFF, CMD_SET_RATE 0xF3, CMD_ENABLE 0xF4;
  - response constants: RSP_ACK 0xFA, RSP_RESEND 0xFE, RSP_ERROR 0xFC, RSP_BAT_OK 0xAA, RSP_ID 0x00;
  - FSM state enum.
- One sub-module: `ps2_timeout_timer`. Ports: clear, enable, expired pulse. Parameter: `TIMEOUT_CYCLES`.

## Test plan
Benches use `TIMEOUT_CYCLES`=64 and a PS2_Controller behavioural model.
- Nominal: ack each send after 10 cycles; reply FA, AA, 00, FA, FA, FA. Required: commands FF, F3, 64, F4 in order; `stream_en`=1 one cycle after the last FA; `retry_count`=0.
- Resend: reply FE to the F3 command, then FA. Required: F3 transmitted twice; `retry_count`=0; completes normally.
- Bad self-test: reply FC instead of AA once. Required: `retry_count`=1; FF re-sent; completes on the second pass.
- Silent mouse: never respond. Required: restart every 64 wait cycles; after the 4th timeout `init_fail`=1, `send_command`=0, `retry_count`=3.
- Transmit error: assert `error_communication_timed_out` together with `command_was_sent` on F4. Required: treated as an error; `retry_count` increments.
- Reset during S_WAIT for 0xAA. Required: all outputs at reset values the next cycle, then FF re-sent.
